// File: rtl/pixel_readout.sv
// pixel_readout: waits for a one-hot row select to settle, captures that row's column ADC values
// into a small row FIFO, and streams the rows pixel-by-pixel on a valid/ready port.
// Optional macro ROW_CHECKSUM_EN appends a modulo-256 checksum beat after each row.
module pixel_readout #(
    parameter  int PIXEL_ARRAY_HEIGHT = 2,
    parameter  int PIXEL_ARRAY_WIDTH  = 2,
    parameter  int SETTLE_CYCLES      = 2,
    parameter  int ROW_BUFFERS        = 2,
    localparam int ROW_W = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1,
    localparam int COL_W = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [PIXEL_ARRAY_HEIGHT-1:0]  row_select,
    input  logic [8*PIXEL_ARRAY_WIDTH-1:0] col_data,
    input  logic                           pixel_ready,
    output logic                           pixel_valid,
    output logic [7:0]                     pixel_data,
    output logic [ROW_W-1:0]               pixel_row,
    output logic [COL_W-1:0]               pixel_col,
    output logic                           frame_start,
    output logic                           frame_end,
`ifdef ROW_CHECKSUM_EN
    output logic                           pixel_is_checksum,
`endif
    output logic                           overflow
);
    localparam int PTR_W = (ROW_BUFFERS > 1) ? $clog2(ROW_BUFFERS) : 1;
    localparam int CNT_W = $clog2(ROW_BUFFERS + 1);
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [COL_W-1:0] COL_LAST    = COL_W'(PIXEL_ARRAY_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(ROW_BUFFERS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(ROW_BUFFERS);

    typedef enum logic {CAP_IDLE, CAP_SETTLE} cap_state_t;
    typedef enum logic {OUT_EMPTY, OUT_STREAM} out_state_t;

    function automatic logic is_onehot(input logic [PIXEL_ARRAY_HEIGHT-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < PIXEL_ARRAY_HEIGHT; i++) n += int'(v[i]);
        return (n == 1);
    endfunction

    function automatic logic [ROW_W-1:0] onehot_index(input logic [PIXEL_ARRAY_HEIGHT-1:0] v);
        logic [ROW_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < PIXEL_ARRAY_HEIGHT; i++) if (v[i]) idx = ROW_W'(i);
        return idx;
    endfunction

    function automatic logic [7:0] pick_col(input logic [8*PIXEL_ARRAY_WIDTH-1:0] row,
                                            input logic [COL_W-1:0] col);
        logic [7:0] px;
        px = '0;
        for (int c = 0; c < PIXEL_ARRAY_WIDTH; c++) if (col == COL_W'(c)) px = row[8*c +: 8];
        return px;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef ROW_CHECKSUM_EN
    function automatic logic [7:0] row_sum(input logic [8*PIXEL_ARRAY_WIDTH-1:0] row);
        logic [7:0] s;
        s = '0;
        for (int c = 0; c < PIXEL_ARRAY_WIDTH; c++) s = s + row[8*c +: 8];
        return s;
    endfunction
`endif

    logic [PIXEL_ARRAY_HEIGHT-1:0]  r_row_sel_prev;
    cap_state_t                     r_cap_state, w_cap_state_next;
    logic [3:0]                     r_settle_cnt, w_settle_cnt_next;
    logic [ROW_W-1:0]               r_cap_row, w_cap_row_next;
    logic                           w_sel_onehot, w_new_row, w_push;

    logic [8*PIXEL_ARRAY_WIDTH-1:0] r_data_mem [ROW_BUFFERS];
    logic [ROW_W-1:0]               r_row_mem  [ROW_BUFFERS];
    logic [PTR_W-1:0]               r_head, r_tail;
    logic [CNT_W-1:0]               r_fifo_cnt, w_fifo_cnt_next;
    logic                           r_overflow, w_drop, w_write, w_pop;

    out_state_t                     r_out_state, w_out_state_next;
    logic [COL_W-1:0]               r_col, w_col_next;
    logic                           w_accept, w_last_beat;
    logic [8*PIXEL_ARRAY_WIDTH-1:0] w_head_data;
    logic [ROW_W-1:0]               w_head_row;
`ifdef ROW_CHECKSUM_EN
    logic                           r_is_cks, w_is_cks_next;
`endif

    assign w_sel_onehot = is_onehot(row_select);
    assign w_new_row    = w_sel_onehot && (row_select != r_row_sel_prev);

    // Capture side: a fresh one-hot select restarts settling; losing the select aborts it.
    always_comb begin
        w_cap_state_next  = r_cap_state;
        w_settle_cnt_next = r_settle_cnt;
        w_cap_row_next    = r_cap_row;
        w_push            = 1'b0;
        case (r_cap_state)
            CAP_IDLE: begin
                if (w_new_row) begin
                    w_cap_state_next  = CAP_SETTLE;
                    w_settle_cnt_next = SETTLE_LOAD;
                    w_cap_row_next    = onehot_index(row_select);
                end
            end
            CAP_SETTLE: begin
                if (!w_sel_onehot) begin
                    w_cap_state_next = CAP_IDLE;
                end else if (w_new_row) begin
                    w_settle_cnt_next = SETTLE_LOAD;
                    w_cap_row_next    = onehot_index(row_select);
                end else if (r_settle_cnt == 4'd0) begin
                    w_push           = 1'b1;
                    w_cap_state_next = CAP_IDLE;
                end else begin
                    w_settle_cnt_next = r_settle_cnt - 4'd1;
                end
            end
            default: w_cap_state_next = CAP_IDLE;
        endcase
    end

    // A capture into a full FIFO is still accepted when the head row leaves on the same edge.
    assign w_accept        = (r_out_state == OUT_STREAM) && pixel_ready;
    assign w_pop           = w_accept && w_last_beat;
    assign w_drop          = w_push && (r_fifo_cnt == CNT_FULL) && !w_pop;
    assign w_write         = w_push && !w_drop;
    assign w_fifo_cnt_next = r_fifo_cnt + CNT_W'(w_write) - CNT_W'(w_pop);

    // Output side: stay streaming across a pop only if another row was already buffered.
    always_comb begin
        w_out_state_next = r_out_state;
        w_col_next       = r_col;
`ifdef ROW_CHECKSUM_EN
        w_is_cks_next    = r_is_cks;
`endif
        case (r_out_state)
            OUT_EMPTY: begin
                w_col_next = '0;
                if (r_fifo_cnt != '0) w_out_state_next = OUT_STREAM;
            end
            OUT_STREAM: begin
                if (w_pop) begin
                    w_col_next = '0;
`ifdef ROW_CHECKSUM_EN
                    w_is_cks_next = 1'b0;
`endif
                    if (r_fifo_cnt <= CNT_W'(1)) w_out_state_next = OUT_EMPTY;
`ifdef ROW_CHECKSUM_EN
                end else if (w_accept && (r_col == COL_LAST)) begin
                    w_is_cks_next = 1'b1;
`endif
                end else if (w_accept) begin
                    w_col_next = r_col + COL_W'(1);
                end
            end
            default: w_out_state_next = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_sel_prev <= '0;
            r_cap_state    <= CAP_IDLE;
            r_settle_cnt   <= '0;
            r_cap_row      <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_fifo_cnt     <= '0;
            r_overflow     <= 1'b0;
            r_out_state    <= OUT_EMPTY;
            r_col          <= '0;
`ifdef ROW_CHECKSUM_EN
            r_is_cks       <= 1'b0;
`endif
        end else begin
            r_row_sel_prev <= row_select;
            r_cap_state    <= w_cap_state_next;
            r_settle_cnt   <= w_settle_cnt_next;
            r_cap_row      <= w_cap_row_next;
            if (w_write) r_tail <= ptr_inc(r_tail);
            if (w_pop)   r_head <= ptr_inc(r_head);
            r_fifo_cnt     <= w_fifo_cnt_next;
            if (w_drop) r_overflow <= 1'b1;
            r_out_state    <= w_out_state_next;
            r_col          <= w_col_next;
`ifdef ROW_CHECKSUM_EN
            r_is_cks       <= w_is_cks_next;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_data_mem[r_tail] <= col_data;
            r_row_mem[r_tail]  <= r_cap_row;
        end
    end

    assign w_head_data = r_data_mem[r_head];
    assign w_head_row  = r_row_mem[r_head];
    assign pixel_valid = (r_out_state == OUT_STREAM);
    assign pixel_row   = pixel_valid ? w_head_row : '0;
    assign overflow    = r_overflow;

`ifdef ROW_CHECKSUM_EN
    assign w_last_beat       = r_is_cks;
    assign pixel_is_checksum = pixel_valid && r_is_cks;
    assign pixel_data        = !pixel_valid ? 8'h00 :
                               (r_is_cks ? row_sum(w_head_data) : pick_col(w_head_data, r_col));
    assign pixel_col         = r_is_cks ? '0 : r_col;
    assign frame_start       = pixel_valid && !r_is_cks && (w_head_row == '0) && (r_col == '0);
    assign frame_end         = pixel_valid && r_is_cks && (w_head_row == ROW_LAST);
`else
    assign w_last_beat = (r_col == COL_LAST);
    assign pixel_data  = pixel_valid ? pick_col(w_head_data, r_col) : 8'h00;
    assign pixel_col   = r_col;
    assign frame_start = pixel_valid && (w_head_row == '0) && (r_col == '0);
    assign frame_end   = pixel_valid && (w_head_row == ROW_LAST) && (r_col == COL_LAST);
`endif
endmodule

// File: tb/tb_pixel_readout.sv
// tb_pixel_readout: directed stimulus for pixel_readout with a transaction-level model of
// row settling, FIFO occupancy and the expected pixel stream, checked every cycle.
module tb_pixel_readout;
    localparam int H  = 2;
    localparam int W  = 2;
    localparam int S  = 2;
    localparam int RB = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [H-1:0] row_select;
    logic [8*W-1:0] col_data;
    logic         pixel_ready;
    logic         pixel_valid;
    logic [7:0]   pixel_data;
    logic [0:0]   pixel_row;
    logic [0:0]   pixel_col;
    logic         frame_start;
    logic         frame_end;
    logic         overflow;
`ifdef ROW_CHECKSUM_EN
    logic         pixel_is_checksum;
`endif

    pixel_readout #(
        .PIXEL_ARRAY_HEIGHT(H), .PIXEL_ARRAY_WIDTH(W), .SETTLE_CYCLES(S), .ROW_BUFFERS(RB)
    ) dut (
        .clk(clk), .reset(reset), .row_select(row_select), .col_data(col_data),
        .pixel_ready(pixel_ready), .pixel_valid(pixel_valid), .pixel_data(pixel_data),
        .pixel_row(pixel_row), .pixel_col(pixel_col), .frame_start(frame_start),
        .frame_end(frame_end),
`ifdef ROW_CHECKSUM_EN
        .pixel_is_checksum(pixel_is_checksum),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected beats, each tagged with the edge on which its row entered the buffer.
    typedef struct {
        logic [7:0] data;
        int         row;
        int         col;
        bit         fs;
        bit         fe;
        bit         cks;
        bit         last;
        int         cap_edge;
    } beat_t;

    beat_t        q[$];
    beat_t        nb;
    logic [H-1:0] hist[$];
    int           edge_n   = -1;
    int           rows_m   = 0;
    bit           ovf_m    = 1'b0;
    bit           acc_pend = 1'b0;
    bit           popped;
    int           cap_row;
    logic [7:0]   sum_m;

    // A row is captured S edges after it first appeared one-hot, provided it stayed selected throughout.
    function automatic bit settle_done(output int r);
        int m;
        int n;
        logic [H-1:0] v;
        logic [H-1:0] pv;
        r = 0;
        m = hist.size() - 1;
        n = m - S;
        if (n < 0) return 1'b0;
        v  = hist[n];
        pv = (n > 0) ? hist[n-1] : '0;
        if ($countones(v) != 1 || v == pv) return 1'b0;
        for (int k = n + 1; k <= m; k++) if (hist[k] != v) return 1'b0;
        for (int i = 0; i < H; i++) if (v[i]) r = i;
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model
        edge_n++;
        if (reset) begin
            q.delete();
            rows_m = 0;
            ovf_m  = 1'b0;
            hist.push_back('0);
        end else begin
            popped = 1'b0;
            if (acc_pend && q.size() > 0) begin
                popped = q[0].last;
                void'(q.pop_front());
                if (popped) rows_m--;
            end
            hist.push_back(row_select);
            if (settle_done(cap_row)) begin
                if (rows_m == RB) begin
                    ovf_m = 1'b1;
                end else begin
                    rows_m++;
                    sum_m = 8'h00;
                    for (int c = 0; c < W; c++) begin
                        nb.data     = col_data[8*c +: 8];
                        nb.row      = cap_row;
                        nb.col      = c;
                        nb.fs       = (cap_row == 0 && c == 0);
                        nb.cks      = 1'b0;
                        nb.cap_edge = edge_n;
`ifdef ROW_CHECKSUM_EN
                        nb.fe       = 1'b0;
                        nb.last     = 1'b0;
`else
                        nb.fe       = (cap_row == H - 1 && c == W - 1);
                        nb.last     = (c == W - 1);
`endif
                        sum_m = sum_m + nb.data;
                        q.push_back(nb);
                    end
`ifdef ROW_CHECKSUM_EN
                    nb.data = sum_m;
                    nb.col  = 0;
                    nb.fs   = 1'b0;
                    nb.fe   = (cap_row == H - 1);
                    nb.cks  = 1'b1;
                    nb.last = 1'b1;
                    q.push_back(nb);
`endif
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        bit ev;
        ev = (q.size() > 0) && (q[0].cap_edge < edge_n);
        check("valid", 32'(pixel_valid), 32'(ev));
        check("overflow", 32'(overflow), 32'(ovf_m));
        if (ev && pixel_valid) begin
            check("data", 32'(pixel_data), 32'(q[0].data));
            check("row", 32'(pixel_row), 32'(q[0].row));
            check("col", 32'(pixel_col), 32'(q[0].col));
            check("frame_start", 32'(frame_start), 32'(q[0].fs));
            check("frame_end", 32'(frame_end), 32'(q[0].fe));
`ifdef ROW_CHECKSUM_EN
            check("is_checksum", 32'(pixel_is_checksum), 32'(q[0].cks));
`endif
        end else if (!pixel_valid) begin
            check("idle_data", 32'(pixel_data), 32'h0);
            check("idle_fs", 32'(frame_start), 32'h0);
            check("idle_fe", 32'(frame_end), 32'h0);
        end
        acc_pend = pixel_valid && pixel_ready;
    end

    int e_now = -1;

    task automatic tick();
        @(posedge clk);
        e_now++;
        #1;
    endtask

    task automatic run_to(input int e);
        while (e_now < e) tick();
    endtask

    task automatic beat(input string name, input logic [7:0] d, input int r, input int c,
                        input bit fs, input bit fe);
        check({name, "_valid"}, 32'(pixel_valid), 32'h1);
        check({name, "_data"}, 32'(pixel_data), 32'(d));
        check({name, "_row"}, 32'(pixel_row), 32'(r));
        check({name, "_col"}, 32'(pixel_col), 32'(c));
        check({name, "_fs"}, 32'(frame_start), 32'(fs));
        check({name, "_fe"}, 32'(frame_end), 32'(fe));
    endtask

    initial begin
        reset = 1'b1; row_select = '0; col_data = '0; pixel_ready = 1'b0;
        run_to(1); reset = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(pixel_valid), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_data", 32'(pixel_data), 32'h0);
`ifdef ROW_CHECKSUM_EN
        run_to(4); row_select = 2'b01; col_data = 16'h20F0; pixel_ready = 1'b1;
        run_to(8);  @(negedge clk); beat("cks_p0", 8'hF0, 0, 0, 1, 0);
        check("cks_p0_flag", 32'(pixel_is_checksum), 32'h0);
        run_to(9);  @(negedge clk); beat("cks_p1", 8'h20, 0, 1, 0, 0);
        run_to(10); @(negedge clk); beat("cks_sum", 8'h10, 0, 0, 0, 0);
        check("cks_sum_flag", 32'(pixel_is_checksum), 32'h1);
        run_to(11); row_select = 2'b10; col_data = 16'h0201;
        run_to(17); @(negedge clk); beat("cks_last", 8'h03, 1, 0, 0, 1);
        run_to(22);
`else
        // Single row with free-flowing ready.
        run_to(4); row_select = 2'b01; col_data = 16'h2211; pixel_ready = 1'b1;
        run_to(7);  @(negedge clk); check("t1_latency", 32'(pixel_valid), 32'h0);
        run_to(8);  @(negedge clk); beat("t1_b0", 8'h11, 0, 0, 1, 0);
        run_to(9);  @(negedge clk); beat("t1_b1", 8'h22, 0, 1, 0, 0);
        run_to(10); row_select = 2'b00; pixel_ready = 1'b0;
        @(negedge clk); check("t1_done", 32'(pixel_valid), 32'h0);
        // Backpressure holds the first beat for four cycles.
        run_to(11); row_select = 2'b01;
        for (int e = 15; e <= 18; e++) begin
            run_to(e);
            if (e == 18) pixel_ready = 1'b1;
            @(negedge clk); beat("t2_hold", 8'h11, 0, 0, 1, 0);
        end
        run_to(19); @(negedge clk); beat("t2_b1", 8'h22, 0, 1, 0, 0);
        run_to(20); row_select = 2'b00;
        @(negedge clk); check("t2_done", 32'(pixel_valid), 32'h0);
        // Full frame; row 1 lands on the edge row 0 is popped.
        run_to(21); row_select = 2'b01; col_data = 16'h2211;
        run_to(24); row_select = 2'b10; col_data = 16'h4433;
        run_to(25); @(negedge clk); beat("t3_b0", 8'h11, 0, 0, 1, 0);
        run_to(27); @(negedge clk); check("t3_gap", 32'(pixel_valid), 32'h0);
        run_to(28); @(negedge clk); beat("t3_b2", 8'h33, 1, 0, 0, 0);
        run_to(29); @(negedge clk); beat("t3_b3", 8'h44, 1, 1, 0, 1);
        // Overflow: third row while two are held.
        run_to(30); pixel_ready = 1'b0; row_select = 2'b01; col_data = 16'h0201;
        run_to(33); row_select = 2'b10; col_data = 16'h0403;
        run_to(36); row_select = 2'b01; col_data = 16'h0605;
        run_to(38); @(negedge clk); check("t4_ovf_pre", 32'(overflow), 32'h0);
        run_to(39); pixel_ready = 1'b1;
        @(negedge clk); check("t4_ovf", 32'(overflow), 32'h1);
        run_to(41); @(negedge clk); beat("t4_reload", 8'h03, 1, 0, 0, 0);
        run_to(43); @(negedge clk); check("t4_drained", 32'(pixel_valid), 32'h0);
        run_to(44); row_select = 2'b00;
        @(negedge clk); check("t4_sticky", 32'(overflow), 32'h1);
        // Aborted settle and multi-hot select.
        run_to(45); row_select = 2'b10;
        run_to(46); row_select = 2'b00;
        run_to(47); row_select = 2'b11;
        for (int e = 48; e <= 52; e++) begin
            run_to(e);
            if (e == 50) row_select = 2'b00;
            @(negedge clk); check("t5_no_capture", 32'(pixel_valid), 32'h0);
        end
        // Reset in the middle of a stalled stream.
        run_to(52); row_select = 2'b01; col_data = 16'h6677; pixel_ready = 1'b0;
        run_to(56); reset = 1'b1; row_select = 2'b00;
        @(negedge clk); beat("t6_pre", 8'h77, 0, 0, 1, 0);
        run_to(57); reset = 1'b0;
        @(negedge clk); check("t6_rst_valid", 32'(pixel_valid), 32'h0);
        check("t6_rst_ovf", 32'(overflow), 32'h0);
        run_to(58); @(negedge clk); check("t6_empty0", 32'(pixel_valid), 32'h0);
        run_to(59); row_select = 2'b10; col_data = 16'h9988; pixel_ready = 1'b1;
        @(negedge clk); check("t6_empty1", 32'(pixel_valid), 32'h0);
        run_to(63); @(negedge clk); beat("t6_b0", 8'h88, 1, 0, 0, 0);
        run_to(64); @(negedge clk); beat("t6_b1", 8'h99, 1, 1, 0, 1);
        run_to(68);
`endif
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
